// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one FPU among NUM_PORTS APU requesters, with per-port
// credit-limited response FIFOs. Optional same-cycle response bypass: CV32E40P_APU_ARB_BYPASS_EN.
package cv32e40p_apu_core_pkg;
  localparam int unsigned APU_NARGS_CPU    = 3;
  localparam int unsigned APU_WOP_CPU      = 6;
  localparam int unsigned APU_NDSFLAGS_CPU = 15;
  localparam int unsigned APU_NUSFLAGS_CPU = 5;
  localparam int unsigned APU_FLAGS_W      = APU_NDSFLAGS_CPU - 4;

  typedef struct packed {
    logic [31:0]                 data;
    logic [APU_NUSFLAGS_CPU-1:0] flags;
  } apu_resp_t;
endpackage

module cv32e40p_apu_arbiter
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned RESP_DEPTH = 2,
  parameter int unsigned TAG_W      = $clog2(NUM_PORTS)
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NUM_PORTS-1:0]                          apu_req_i,
  output logic [NUM_PORTS-1:0]                          apu_gnt_o,
  input  logic [NUM_PORTS-1:0][APU_NARGS_CPU-1:0][31:0] apu_operands_i,
  input  logic [NUM_PORTS-1:0][APU_WOP_CPU-1:0]         apu_op_i,
  input  logic [NUM_PORTS-1:0][APU_FLAGS_W-1:0]         apu_flags_i,
  output logic [NUM_PORTS-1:0]                          apu_rvalid_o,
  input  logic [NUM_PORTS-1:0]                          apu_rready_i,
  output logic [NUM_PORTS-1:0][31:0]                    apu_rdata_o,
  output logic [NUM_PORTS-1:0][APU_NUSFLAGS_CPU-1:0]    apu_rflags_o,
  output logic                                          fpu_req_o,
  input  logic                                          fpu_gnt_i,
  output logic [APU_NARGS_CPU-1:0][31:0]                fpu_operands_o,
  output logic [APU_WOP_CPU-1:0]                        fpu_op_o,
  output logic [APU_FLAGS_W-1:0]                        fpu_flags_o,
  output logic [TAG_W-1:0]                              fpu_tag_o,
  input  logic                                          fpu_rvalid_i,
  input  logic [TAG_W-1:0]                              fpu_rtag_i,
  input  logic [31:0]                                   fpu_rdata_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]                   fpu_rflags_i,
  output logic                                          err_o
);

  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] sel_oh;
  logic [NUM_PORTS-1:0] lock_oh;
  logic                 any_elig;
  logic                 lock_hit;
  logic                 hs;
  logic                 rr_found;
  logic [TAG_W-1:0]     rr_sel;
  logic [TAG_W-1:0]     sel;
  logic [TAG_W-1:0]     ptr_q, ptr_d;
  logic [TAG_W-1:0]     lock_sel_q;
  logic                 lock_q, lock_d;
  logic                 err_q, err_d;
  logic                 rtag_ok;
  apu_resp_t            resp_in;

  assign resp_in  = {fpu_rdata_i, fpu_rflags_i};
  assign rtag_ok  = (32'(fpu_rtag_i) < NUM_PORTS);
  assign any_elig = |eligible;

  // A held lock only survives while its requester still asks, so a dropped request is never granted.
  always_comb begin
    lock_oh = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      lock_oh[i] = (lock_sel_q == TAG_W'(i));
    end
  end

  assign lock_hit = lock_q & |(apu_req_i & lock_oh);

  // Round-robin search starting one past the last granted port.
  always_comb begin
    rr_sel   = ptr_q;
    rr_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (!rr_found && eligible[i] && (i == (32'(ptr_q) + k) % NUM_PORTS)) begin
          rr_found = 1'b1;
          rr_sel   = TAG_W'(i);
        end
      end
    end
  end

  assign sel       = lock_hit ? lock_sel_q : rr_sel;
  assign fpu_req_o = rst_ni & (any_elig | lock_hit);
  assign hs        = fpu_req_o & fpu_gnt_i;
  assign fpu_tag_o = sel;

  always_comb begin
    sel_oh         = '0;
    fpu_operands_o = '0;
    fpu_op_o       = '0;
    fpu_flags_o    = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      sel_oh[i] = (sel == TAG_W'(i));
      if (sel == TAG_W'(i)) begin
        fpu_operands_o = apu_operands_i[i];
        fpu_op_o       = apu_op_i[i];
        fpu_flags_o    = apu_flags_i[i];
      end
    end
  end

  assign apu_gnt_o = sel_oh & {NUM_PORTS{hs}};

  always_comb begin
    ptr_d  = hs ? sel : ptr_q;
    lock_d = fpu_req_o & ~fpu_gnt_i;
    err_d  = err_q | (fpu_rvalid_i & ~rtag_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= TAG_W'(NUM_PORTS - 1);
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_sel_q <= sel;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    apu_resp_t        mem_q [RESP_DEPTH];
    apu_resp_t        head;
    logic [PTR_W-1:0] wr_q, rd_q, wr_nxt, rd_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cred_q, cred_d;
    logic             push_req, push, pop_fifo, take, empty, bypass, rvalid;

    assign push_req = fpu_rvalid_i & rtag_ok & (fpu_rtag_i == TAG_W'(p));
    assign empty    = (cnt_q == '0);
`ifdef CV32E40P_APU_ARB_BYPASS_EN
    assign bypass   = rst_ni & push_req & empty & apu_rready_i[p];
`else
    assign bypass   = 1'b0;
`endif
    assign push     = push_req & ~bypass;
    assign rvalid   = ~empty | bypass;
    assign take     = rvalid & apu_rready_i[p];
    assign pop_fifo = take & ~empty;
    assign head     = empty ? resp_in : mem_q[rd_q];

    assign apu_rvalid_o[p] = rvalid;
    assign apu_rdata_o[p]  = head.data;
    assign apu_rflags_o[p] = head.flags;
    assign eligible[p]     = apu_req_i[p] & (cred_q < CNT_W'(RESP_DEPTH));

    assign wr_nxt = (wr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
    assign rd_nxt = (rd_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);

    // Credit counts in-flight plus buffered responses; a bypassed response is granted-then-taken.
    always_comb begin
      cnt_d  = cnt_q;
      cred_d = cred_q;
      if (push && !pop_fifo) cnt_d = cnt_q + CNT_W'(1);
      else if (!push && pop_fifo) cnt_d = cnt_q - CNT_W'(1);
      if (apu_gnt_o[p] && !take) cred_d = cred_q + CNT_W'(1);
      else if (!apu_gnt_o[p] && take) cred_d = cred_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_q   <= '0;
        rd_q   <= '0;
        cnt_q  <= '0;
        cred_q <= '0;
        for (int unsigned e = 0; e < RESP_DEPTH; e++) mem_q[e] <= '0;
      end else begin
        cnt_q  <= cnt_d;
        cred_q <= cred_d;
        if (push) begin
          mem_q[wr_q] <= resp_in;
          wr_q        <= wr_nxt;
        end
        if (pop_fifo) rd_q <= rd_nxt;
      end
    end
  end

endmodule

// File: doc/cv32e40p_apu_arbiter.md
CV32E40P_APU_ARBITER -- requirements
Module: cv32e40p_apu_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of APU requester ports (legal 2..8).
REQ-002 SHALL have parameter RESP_DEPTH, default 2, per-port response FIFO depth and credit limit (legal 1..8).
REQ-003 SHALL have parameter TAG_W, default $clog2(NUM_PORTS), width of the downstream tag.
REQ-004 SHALL use operand, op, flag and status widths APU_NARGS_CPU x 32, APU_WOP_CPU, APU_NDSFLAGS_CPU-4 and APU_NUSFLAGS_CPU from cv32e40p_apu_core_pkg.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-006 SHALL have the requester ports (i = port index, i = 0..NUM_PORTS-1):
- apu_req_i  in  NUM_PORTS  request
- apu_gnt_o  out  NUM_PORTS  grant
- apu_operands_i  in  per port  operands
- apu_op_i  in  per port  op
- apu_flags_i  in  per port  flags
- apu_rvalid_o  out  NUM_PORTS  response valid
- apu_rready_i  in  NUM_PORTS  response ready
- apu_rdata_o  out  per port x 32  result
- apu_rflags_o  out  per port  status
REQ-007 SHALL have the downstream FPU ports:
- fpu_req_o  out  1  request
- fpu_gnt_i  in  1  grant
- fpu_operands_o, fpu_op_o, fpu_flags_o  out  selected port's fields
- fpu_tag_o  out  TAG_W  index of the selected port
- fpu_rvalid_i  in  1  response valid, always accepted
- fpu_rtag_i  in  TAG_W  response tag
- fpu_rdata_i  in  32  result
- fpu_rflags_i  in  APU_NUSFLAGS_CPU  status
REQ-008 SHALL have err_o  out  1, a sticky flag for an illegal response tag.

Function
REQ-009 SHALL treat port i as eligible when apu_req_i[i]=1 and credit[i] < RESP_DEPTH.
REQ-010 SHALL arbitrate round-robin: search starts at ptr+1 modulo NUM_PORTS; ptr moves to the granted index only on handshake (fpu_req_o & fpu_gnt_i).
REQ-011 SHALL assert fpu_req_o whenever any port is eligible or a lock is held; the downstream fields SHALL mux from the selected port.
REQ-012 SHALL lock the selection while fpu_req_o=1 and fpu_gnt_i=0, so a stalled request keeps its port, fields and tag stable until the handshake.
REQ-013 SHALL drive apu_gnt_o[i] = fpu_gnt_i & fpu_req_o & (sel==i), combinationally in the same cycle.
REQ-014 SHALL keep credit[i] = in-flight count plus FIFO occupancy of port i:
- +1 on grant to i; -1 on pop (apu_rvalid_o[i] & apu_rready_i[i]); both in one cycle -> unchanged.
- credit[i] SHALL never exceed RESP_DEPTH.
REQ-015 SHALL push {fpu_rdata_i, fpu_rflags_i} into FIFO[fpu_rtag_i] when fpu_rvalid_i=1; the credit rule guarantees no overflow.
REQ-016 SHALL, when fpu_rvalid_i=1 and fpu_rtag_i >= NUM_PORTS, drop the response and set err_o until reset.
REQ-017 SHALL assert apu_rvalid_o[i] whenever FIFO[i] is non-empty and show its head, with default latency 1 cycle from fpu_rvalid_i to apu_rvalid_o.
REQ-018 SHALL allow simultaneous push and pop on the same FIFO, including when the FIFO is full-1 or full; occupancy and order SHALL be preserved.
REQ-019 SHALL wrap FIFO pointers modulo RESP_DEPTH and return responses in FPU return order per port.
REQ-020 SHALL allow apu_req_i to drop before grant; no grant SHALL then be issued to that port.

Reset
REQ-021 SHALL, while rst_ni=0 (asynchronous):
- clear all FIFOs, credits, the lock and err_o
- set ptr = NUM_PORTS-1, so port 0 has first priority
- drive apu_gnt_o=0, apu_rvalid_o=0, fpu_req_o=0
REQ-022 SHALL, on reset mid-operation, discard in-flight and buffered responses; the integrator SHALL reset the FPU in the same cycle.

Configuration
REQ-023 SHALL implement the macro CV32E40P_APU_ARB_BYPASS_EN as follows:
- Defined: if FIFO[i] is empty and apu_rready_i[i]=1, a tag-i response SHALL appear on apu_rvalid_o[i] in the same cycle and not be stored (push and pop cancel for credit).
- Undefined: every response SHALL go through the FIFO with 1-cycle latency.

Verification
REQ-024 SHALL cover: apu_req_i=2'b11 continuously, fpu_gnt_i=1 -> grants alternate 0,1,0,1 starting with port 0 after reset.
REQ-025 SHALL cover: port 1 request with fpu_gnt_i=0 for 3 cycles, port 0 requesting meanwhile -> fpu_tag_o stays 1 and fields stay stable; grant goes to port 1 first.
REQ-026 SHALL cover: RESP_DEPTH=2, apu_rready_i[0]=0, 3 requests on port 0 -> only 2 granted; after one pop, the third is granted the next cycle.
REQ-027 SHALL cover: responses tagged 1,0,1 with data 0xA,0xB,0xC -> port1 sees 0xA then 0xC, port0 sees 0xB, each 1 cycle later (0 cycles with CV32E40P_APU_ARB_BYPASS_EN and ready=1).
REQ-028 SHALL cover: NUM_PORTS=3, fpu_rtag_i=3 with valid -> response dropped, err_o=1 until rst_ni=0.
REQ-029 SHALL cover: rst_ni low with 2 responses buffered -> apu_rvalid_o=0 immediately and credits return to 0.
